// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_t      : controller states (IDLE, SHIFT, DONE)
//   - DEF_BIN_W    : default binary input width
//   - DEF_DIGITS   : default number of BCD digits produced
//   - BCD_DIGIT_W  : width of one packed BCD digit
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int DEF_BIN_W   = 12;
    localparam int DEF_DIGITS  = 4;
    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bin2bcd_pkg

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_in  : BCD digit before the shift
//   digit_out : corrected digit (4-bit result, no carry out)
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Inputs are always 0..9, so 5..9 maps to 8..12 and never overflows 4 bits.
    assign digit_out = (digit_in >= BCD_DIGIT_W'(5)) ? digit_in + BCD_DIGIT_W'(3)
                                                      : digit_in;

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_ctrl
// Sequential shift-and-add-3 converter: one shared bank of digit adjusters is
// reused over BIN_W iterations to turn a captured binary word into packed BCD.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only in IDLE
//   bin_in   : value to convert, captured on the accepting edge
//   busy     : high while the conversion iterates (SHIFT)
//   done     : one-cycle pulse when bcd_out carries the new result
//   bcd_out  : packed BCD result, digit 0 in bits [3:0]
//
// Handshake: start is accepted on a rising edge while the FSM is IDLE; from
// that edge busy stays high for BIN_W cycles, then done pulses for one cycle
// with the new bcd_out. start seen during SHIFT or DONE is dropped, not queued.
// bcd_out only changes on the edge that enters DONE and otherwise holds.
// -----------------------------------------------------------------------------
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [BCD_W-1:0]       bcd_acc;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_q;
    logic [BIN_W-1:0]       bin_acc;
    logic [CNT_W-1:0]       cnt;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   load;
    logic                   step;
    logic                   last;

    // Shared adjust datapath, one instance per digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One iteration: adjust all digits, then shift the whole register left.
    assign shifted = {bcd_adj, bin_acc} << 1;
    assign last    = (cnt == LAST_CNT);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_acc <= '0;
            bin_acc <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
        end else if (load) begin
            bcd_acc <= '0;
            bin_acc <= bin_in;
            cnt     <= '0;
        end else if (step) begin
            {bcd_acc, bin_acc} <= shifted;
            cnt                <= cnt + CNT_W'(1);
            // Final iteration: publish the shifted digits directly.
            if (last) begin
                bcd_q <= shifted[BCD_W+BIN_W-1 -: BCD_W];
            end
        end
    end

    assign bcd_out = bcd_q;

endmodule : bin2bcd_seq_ctrl

// File: tb/tb_bin2bcd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq_ctrl
// Directed bench for bin2bcd_seq_ctrl (BIN_W=12, DIGITS=4). Latency is counted
// in rising edges after the accepting edge; done is expected after edge 12.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq_ctrl;

    localparam int BIN_W  = 12;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcd_out;

    int n_checks;
    int n_fail;

    logic [BCD_W-1:0] exp_q[$];

    bin2bcd_seq_ctrl #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Launches one conversion and follows it to done. Reports latency, whether
    // busy was high every SHIFT cycle and low at done, and whether bcd_out held.
    task automatic run_conv(input logic [BIN_W-1:0] v, output int lat,
                            output bit busy_ok, output bit hold_ok,
                            output bit timeout);
        logic [BCD_W-1:0] prev;
        int w;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        timeout = 1'b0;
        start   = 1'b1;
        bin_in  = v;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!busy && w < 20);
        start  = 1'b0;
        bin_in = ~v;
        if (!busy) begin
            timeout = 1'b1;
            return;
        end
        prev = bcd_out;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!done) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (bcd_out !== prev) hold_ok = 1'b0;
            end
        end while (!done && lat < 30);
        if (!done) timeout = 1'b1;
        else if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b bcd=%h, need 0 0 0000",
                     busy, done, bcd_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat;
        bit bok, hok, to;
        run_conv(12'd0, lat, bok, hok, to);
        n_checks++;
        if (to !== 1'b0 || lat != 12) begin
            n_fail++;
            $display("FAIL zero_latency: timeout=%b edges=%0d, need 0 and 12", to, lat);
        end
        n_checks++;
        if (bcd_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_result: got %h, need 0000", bcd_out);
        end
        n_checks++;
        if (bok !== 1'b1 || hok !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy_hold: busy_ok=%b hold_ok=%b, need 1 1", bok, hok);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [BIN_W-1:0] vin [4];
        logic [BCD_W-1:0] vexp[4];
        logic [BCD_W-1:0] e;
        int lat;
        bit bok, hok, to;
        vin[0] = 12'd4095; vexp[0] = 16'h4095;
        vin[1] = 12'd1234; vexp[1] = 16'h1234;
        vin[2] = 12'd5;    vexp[2] = 16'h0005;
        vin[3] = 12'd1000; vexp[3] = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vexp[i]);
            run_conv(vin[i], lat, bok, hok, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to !== 1'b0 || bcd_out !== e) begin
                n_fail++;
                $display("FAIL directed_%0d: timeout=%b got %h, need %h", vin[i], to, bcd_out, e);
            end
            n_checks++;
            if (lat != 12 || bok !== 1'b1 || hok !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_timing_%0d: edges=%0d busy_ok=%b hold_ok=%b, need 12 1 1",
                         vin[i], lat, bok, hok);
            end
        end
    endtask

    task automatic test_ignored_start;
        int n_done;
        logic [BCD_W-1:0] res;
        n_done = 0;
        res    = '0;
        // Make sure the DUT is back in IDLE before the accept edge.
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 12'd42;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 12'd999;
        @(posedge clk); #1;          // E0+3
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                res = bcd_out;
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignored_start_count: done pulses=%0d, need 1", n_done);
        end
        n_checks++;
        if (res !== 16'h0042) begin
            n_fail++;
            $display("FAIL ignored_start_result: got %h, need 0042", res);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, n_done;
        int t_done[2];
        logic [BCD_W-1:0] res[2];
        cyc = 0;
        n_done = 0;
        t_done[0] = 0; t_done[1] = 0;
        res[0] = '0;   res[1] = '0;
        start  = 1'b1;
        bin_in = 12'd7;
        while (n_done < 2 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                t_done[n_done] = cyc;
                res[n_done]    = bcd_out;
                n_done++;
                bin_in = 12'd300;
                if (n_done == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_count: done pulses=%0d within bound, need 2", n_done);
        end
        n_checks++;
        if (res[0] !== 16'h0007 || res[1] !== 16'h0300) begin
            n_fail++;
            $display("FAIL b2b_results: got %h %h, need 0007 0300", res[0], res[1]);
        end
        n_checks++;
        if (t_done[1] - t_done[0] != 14) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, need 14", t_done[1] - t_done[0]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n_done, lat;
        bit bok, hok, to;
        n_done = 0;
        start  = 1'b1;
        bin_in = 12'd777;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;                // asserted between E0+5 and E0+6
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b done=%b bcd=%h, need 0 0 0000",
                     busy, done, bcd_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: done pulses=%0d, need 0", n_done);
        end
        run_conv(12'd777, lat, bok, hok, to);
        n_checks++;
        if (to !== 1'b0 || bcd_out !== 16'h0777) begin
            n_fail++;
            $display("FAIL midreset_restart: timeout=%b got %h, need 0777", to, bcd_out);
        end
    endtask

    task automatic test_sweep;
        int order[4096];
        int j, tmp, lat;
        bit bok, hok, to, digit_bad;
        logic [BCD_W-1:0] e;
        for (int i = 0; i < 4096; i++) order[i] = i;
        for (int i = 4095; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 4096; i++) begin
            exp_q.push_back(ref_bcd(order[i]));
            run_conv(BIN_W'(order[i]), lat, bok, hok, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to !== 1'b0 || bcd_out !== e) begin
                n_fail++;
                $display("FAIL sweep_%0d: timeout=%b got %h, need %h", order[i], to, bcd_out, e);
            end
            digit_bad = 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd_out[d*4 +: 4] > 4'd9) digit_bad = 1'b1;
            end
            n_checks++;
            if (digit_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_digit_%0d: got %h, every digit must be <= 9", order[i], bcd_out);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin_in   = '0;
        test_reset();
        test_zero();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bin2bcd_seq_ctrl

// File: doc/bin2bcd_seq_ctrl.md
# bin2bcd_seq_ctrl

Sequential controller that converts a captured binary word to packed BCD with the shift-and-add-3 (double-dabble) algorithm. It time-shares one per-digit "≥5 → +3" adjust datapath across BIN_W iterations. It sits between the binary counter/measurement logic and the 7-segment display path. A start/busy/done handshake lets upstream logic launch one conversion at a time.

## Interface
- BIN_W, 12: binary input width; one iteration per bit.
- DIGITS, 4: BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W − 1.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- bin_in  input  BIN_W  value to convert; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; bcd_out valid.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0].

## Operation
- Internal registers:
  - shift register {bcd_acc[4*DIGITS-1:0], bin_acc[BIN_W-1:0]}.
  - iteration counter cnt, width clog2(BIN_W+1).
  - result register bcd_q.
- States:
  - IDLE: wait for start. On start=1: bin_acc←bin_in, bcd_acc←0, cnt←0, go to SHIFT.
  - SHIFT: each cycle:
    - Every digit of bcd_acc that is ≥5 gets +3 (4-bit result, no carry between digits).
    - The whole {bcd_acc, bin_acc} then shifts left by 1, and cnt increments.
    - When cnt reaches BIN_W−1 on this edge: bcd_q←the shifted bcd_acc, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Accepting start:
  - start is ignored in SHIFT and DONE; nothing is queued.
  - bin_in changes after capture do not affect the running conversion.
- bcd_out = bcd_q:
  - Holds the last result until the next conversion completes.
  - Does not change during SHIFT.
- Digits never exceed 9 at any point, so no invalid-digit handling is needed.
- Reset (rst_n=0, at any time including mid-SHIFT):
  - Immediately forces IDLE, cnt=0, accumulators=0, bcd_q=0.
  - Outputs: busy=0, done=0, bcd_out=0.
  - The partial conversion is discarded; no done is ever issued for it.

## Timing
- start accepted at edge E0. busy=1 from E0 through edge E0+BIN_W.
- Shift iterations occur at edges E0+1 … E0+BIN_W.
- done=1 and the new bcd_out are visible in the cycle after edge E0+BIN_W.
  - For the defaults: done follows start by 13 cycles.
- done falls at E0+BIN_W+1. The earliest next accept edge is E0+BIN_W+2.
  - Throughput: one conversion per BIN_W+2 cycles.
- start held high continuously gives back-to-back conversions at that rate, all using the bin_in value at each accept edge.
- Outputs come from registers/state only; there is no combinational path from start or bin_in to any output.

## Structure
- Shared package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default BIN_W/DIGITS constants;
  - the BCD digit width constant (4).
- One sub-module, bcd_digit_adj:
  - Combinational; 4-bit in, 4-bit out; output is in+3 when in ≥5, else in.
  - Instantiated DIGITS times in a generate loop.
- The FSM, counter and shift register live in the top.

## Test plan
- Reset, then bin_in=0, start pulse → done 13 cycles later, bcd_out=16'h0000, busy low afterwards.
- bin_in=4095 → bcd_out=16'h4095. bin_in=1234 → 16'h1234. bin_in=5 → 16'h0005. bin_in=1000 → 16'h1000.
- Start at E0 with bin_in=42. At E0+3, pulse start with bin_in=999 → second start ignored; result 16'h0042; exactly one done.
- start held high with bin_in alternating 7/300 at each accept edge → results 16'h0007, 16'h0300; done pulses spaced 14 cycles apart.
- rst_n asserted at E0+6 of a conversion of 777 → busy=0, bcd_out=0 immediately; no done. A new start with 777 → 16'h0777.
- Exhaustive random sweep of 0–4095 against a reference model (value → decimal digits): bcd_out matches and every digit is ≤9 for all values.
